// File: rtl/field_stream_arbiter.sv
// Packet-atomic round-robin arbiter: two Avalon-ST pixel sinks share one source.
// Orphan beats (no SOP while idle) are discarded and counted for debug.
module field_stream_arbiter #(
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int DROP_CNT_W       = 16,
    localparam int DATA_WIDTH      = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] din0_data,
    input  logic                  din0_valid,
    input  logic                  din0_startofpacket,
    input  logic                  din0_endofpacket,
    output logic                  din0_ready,
    input  logic [DATA_WIDTH-1:0] din1_data,
    input  logic                  din1_valid,
    input  logic                  din1_startofpacket,
    input  logic                  din1_endofpacket,
    output logic                  din1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic [1:0]            grant,
    output logic [DROP_CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rr_ptr;
    logic                  rr_nxt;
    logic                  out_free;
    logic                  cand0;
    logic                  cand1;
    logic                  orph0;
    logic                  orph1;
    logic [1:0]            drop_inc;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_sop;
    logic                  load_eop;
    logic [DROP_CNT_W:0]   drop_sum;

    // Output register can take a beat when empty or being drained this cycle.
    assign out_free = dout_ready | ~dout_valid;

    assign cand0 = din0_valid & din0_startofpacket;
    assign cand1 = din1_valid & din1_startofpacket;
    assign orph0 = din0_valid & ~din0_startofpacket;
    assign orph1 = din1_valid & ~din1_startofpacket;

    assign grant = {state == OWN1, state == OWN0};

    assign drop_sum = {1'b0, drop_count}
                    + {{(DROP_CNT_W-1){1'b0}}, drop_inc};

    // Arbitration, handshake and next-state decision.
    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        din0_ready = 1'b0;
        din1_ready = 1'b0;
        drop_inc   = 2'd0;
        load       = 1'b0;
        load_data  = din0_data;
        load_sop   = din0_startofpacket;
        load_eop   = din0_endofpacket;
        unique case (state)
            IDLE: begin
                din0_ready = orph0;
                din1_ready = orph1;
                drop_inc   = {1'b0, orph0} + {1'b0, orph1};
                if (cand0 && cand1) begin
                    state_nxt = rr_ptr ? OWN1 : OWN0;
                end else if (cand0) begin
                    state_nxt = OWN0;
                end else if (cand1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                din0_ready = out_free;
                if (din0_valid && out_free) begin
                    load = 1'b1;
                    if (din0_endofpacket) begin
                        state_nxt = IDLE;
                        rr_nxt    = 1'b1;
                    end
                end
            end
            OWN1: begin
                din1_ready = out_free;
                load_data  = din1_data;
                load_sop   = din1_startofpacket;
                load_eop   = din1_endofpacket;
                if (din1_valid && out_free) begin
                    load = 1'b1;
                    if (din1_endofpacket) begin
                        state_nxt = IDLE;
                        rr_nxt    = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner state and round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Registered output stage; holds its beat while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout_valid         <= 1'b0;
            dout_data          <= '0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
        end else if (load) begin
            dout_valid         <= 1'b1;
            dout_data          <= load_data;
            dout_startofpacket <= load_sop;
            dout_endofpacket   <= load_eop;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Saturating count of discarded orphan beats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_sum[DROP_CNT_W]) begin
            drop_count <= '1;
        end else begin
            drop_count <= drop_sum[DROP_CNT_W-1:0];
        end
    end

endmodule
